// File: rtl/lock_window_arbiter.sv
// lock_window_arbiter
// Two requesters share one protected register. The winner of round-robin
// arbitration has its key and write data captured. A matching key opens a
// WINDOW-cycle unlock window that drives the captured data onto d, and the
// block then re-locks. MAX_FAIL consecutive key mismatches latch a lockout
// that only resetn clears.
//
// Handshake: a requester raises req[i] and holds it until ack[i] or nack[i].
// ack[i] and nack[i] are one-cycle completion pulses, and only one of them
// fires per operation. A requester that still shows req[i] during its own
// completion cycle is not treated as a fresh request in that cycle. Once
// req[i] has been sampled, later changes to req[i], key[i] and wdata[i] are
// ignored until the operation completes.
module lock_window_arbiter #(
    parameter int                DATA_W   = 8,
    parameter int                KEY_W    = 8,
    parameter logic [KEY_W-1:0]  KEY      = KEY_W'('hA5),
    parameter int                WINDOW   = 4,
    parameter int                MAX_FAIL = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [1:0]                    req,
    input  logic [KEY_W-1:0]              key0,
    input  logic [KEY_W-1:0]              key1,
    input  logic [DATA_W-1:0]             wdata0,
    input  logic [DATA_W-1:0]             wdata1,
    output logic [1:0]                    grant,
    output logic [1:0]                    ack,
    output logic [1:0]                    nack,
    output logic                          unlock,
    output logic [DATA_W-1:0]             d,
    output logic                          lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic [2:0]                    state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        RELOCK  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam int FC_W  = $clog2(MAX_FAIL + 1);
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAIL - 1);

    state_t              state, state_n;
    logic [1:0]          grant_n, ack_n, nack_n;
    logic                unlock_n, lockout_n;
    logic [DATA_W-1:0]   d_n;
    logic [FC_W-1:0]     fail_cnt_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [KEY_W-1:0]    cap_key, cap_key_n;
    logic [DATA_W-1:0]   cap_data, cap_data_n;
    logic                rr_last, rr_last_n;   // 1: requester 1 was granted last
    logic [1:0]          eligible;
    logic                pick1;

    assign state_dbg = state;

    // A completion pulse is the requester's release, so a still-high req in
    // that cycle does not count as a new request.
    assign eligible = req & ~ack & ~nack;

    // Requester 1 wins when it is alone, or when both ask and 0 went last.
    assign pick1 = eligible[1] & (~eligible[0] | ~rr_last);

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        ack_n      = 2'b00;
        nack_n     = 2'b00;
        unlock_n   = 1'b0;
        d_n        = d;
        lockout_n  = lockout;
        fail_cnt_n = fail_cnt;
        cnt_n      = cnt;
        cap_key_n  = cap_key;
        cap_data_n = cap_data;
        rr_last_n  = rr_last;

        case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    // Captured operands are stable; compare them next.
                    state_n = CHECK;
                end else if (eligible != 2'b00) begin
                    if (pick1) begin
                        grant_n    = 2'b10;
                        cap_key_n  = key1;
                        cap_data_n = wdata1;
                        rr_last_n  = 1'b1;
                    end else begin
                        grant_n    = 2'b01;
                        cap_key_n  = key0;
                        cap_data_n = wdata0;
                        rr_last_n  = 1'b0;
                    end
                end
            end

            CHECK: begin
                if (cap_key == KEY) begin
                    fail_cnt_n = '0;
                    cnt_n      = '0;
                    unlock_n   = 1'b1;
                    d_n        = cap_data;
                    state_n    = OPEN;
                end else begin
                    nack_n  = grant;
                    grant_n = 2'b00;
                    if (fail_cnt >= FC_LAST) begin
                        fail_cnt_n = FC_MAX;
                        lockout_n  = 1'b1;
                        state_n    = LOCKOUT;
                    end else begin
                        fail_cnt_n = fail_cnt + 1'b1;
                        state_n    = IDLE;
                    end
                end
            end

            OPEN: begin
                if (cnt == CNT_LAST) begin
                    ack_n   = grant;
                    state_n = RELOCK;
                end else begin
                    unlock_n = 1'b1;
                    cnt_n    = cnt + 1'b1;
                end
            end

            RELOCK: begin
                grant_n = 2'b00;
                state_n = IDLE;
            end

            LOCKOUT: begin
                // Every request is refused; nack is its completion, so a
                // held request is refused every other cycle.
                grant_n = 2'b00;
                nack_n  = req & ~nack;
            end

            default: begin
                grant_n = 2'b00;
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops unlock without a clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grant    <= 2'b00;
            ack      <= 2'b00;
            nack     <= 2'b00;
            unlock   <= 1'b0;
            d        <= '0;
            lockout  <= 1'b0;
            fail_cnt <= '0;
            cnt      <= '0;
            cap_key  <= '0;
            cap_data <= '0;
            rr_last  <= 1'b1;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            ack      <= ack_n;
            nack     <= nack_n;
            unlock   <= unlock_n;
            d        <= d_n;
            lockout  <= lockout_n;
            fail_cnt <= fail_cnt_n;
            cnt      <= cnt_n;
            cap_key  <= cap_key_n;
            cap_data <= cap_data_n;
            rr_last  <= rr_last_n;
        end
    end

endmodule

// File: tb/tb_lock_window_arbiter.sv
// Bench for lock_window_arbiter: directed stimulus, a transaction-level
// model checked every cycle, and literal expectations for key scenarios.
module tb_lock_window_arbiter;

    localparam int         W        = 4;
    localparam int         MAX_FAIL = 3;
    localparam logic [7:0] KEY      = 8'hA5;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [7:0] key0   = 8'h00;
    logic [7:0] key1   = 8'h00;
    logic [7:0] wdata0 = 8'h00;
    logic [7:0] wdata1 = 8'h00;
    logic [1:0] grant, ack, nack;
    logic       unlock, lockout;
    logic [7:0] d;
    logic [1:0] fail_cnt;
    logic [2:0] state_dbg;

    lock_window_arbiter #(
        .DATA_W(8), .KEY_W(8), .KEY(KEY), .WINDOW(W), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .key0(key0), .key1(key1), .wdata0(wdata0), .wdata1(wdata1),
        .grant(grant), .ack(ack), .nack(nack), .unlock(unlock), .d(d),
        .lockout(lockout), .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Protected register: loads d whenever unlocked, keeps its value over reset.
    logic [7:0] prot_reg = 8'h00;
    always @(posedge clk) if (unlock) prot_reg <= d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: each operation is timed by its cycle offset k from
    // the grant edge. Good key: grant k=0..W+2, unlock k=2..W+1, ack k=W+2,
    // next arbitration at end of k=W+3. Bad key: grant k=0..1, nack k=2,
    // next arbitration at end of k=2.
    logic       m_act, m_rr, m_lock;
    int         m_k, m_own, m_fail;
    logic [7:0] m_key, m_data;
    logic [1:0] exp_grant, exp_ack, exp_nack;
    logic       exp_unlock;
    logic [7:0] exp_d;

    always @(posedge clk or negedge resetn) begin : model
        logic       act, rr, lk, good, u;
        int         k, own, fc;
        logic [7:0] mk, md, dd;
        logic [1:0] elig, g, a, n;
        if (!resetn) begin
            m_act <= 1'b0; m_k <= 0; m_own <= 0; m_key <= 8'h00; m_data <= 8'h00;
            m_rr <= 1'b1; m_fail <= 0; m_lock <= 1'b0;
            exp_grant <= 2'b00; exp_ack <= 2'b00; exp_nack <= 2'b00;
            exp_unlock <= 1'b0; exp_d <= 8'h00;
        end else begin
            act = m_act; k = m_k; own = m_own; mk = m_key; md = m_data;
            rr = m_rr; fc = m_fail; lk = m_lock; dd = exp_d;
            g = 2'b00; a = 2'b00; n = 2'b00; u = 1'b0;
            if (lk) begin
                n   = req & ~exp_nack;
                act = 1'b0;
            end else begin
                good = (mk == KEY);
                if (act && ((good && k == W + 3) || (!good && k == 2))) act = 1'b0;
                if (act) begin
                    k = k + 1;
                end else begin
                    elig = req & ~exp_nack & ~exp_ack;
                    if (elig != 2'b00) begin
                        if (elig == 2'b11) own = rr ? 0 : 1;
                        else               own = elig[1] ? 1 : 0;
                        mk  = (own == 1) ? key1 : key0;
                        md  = (own == 1) ? wdata1 : wdata0;
                        rr  = (own == 1);
                        act = 1'b1;
                        k   = 0;
                    end
                end
                good = (mk == KEY);
                if (act) begin
                    if (k == 2) begin
                        if (good) begin
                            fc = 0;
                            dd = md;
                        end else begin
                            fc = fc + 1;
                            if (fc >= MAX_FAIL) lk = 1'b1;
                        end
                    end
                    if ((good && k <= W + 2) || (!good && k <= 1)) g = 2'b01 << own;
                    if (good && k >= 2 && k <= W + 1) u = 1'b1;
                    if (good && k == W + 2) a = 2'b01 << own;
                    if (!good && k == 2) n = 2'b01 << own;
                end
            end
            m_act <= act; m_k <= k; m_own <= own; m_key <= mk; m_data <= md;
            m_rr <= rr; m_fail <= fc; m_lock <= lk;
            exp_grant <= g; exp_ack <= a; exp_nack <= n; exp_unlock <= u; exp_d <= dd;
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (chk_en && resetn) begin
            check("grant",    32'(grant),    32'(exp_grant));
            check("ack",      32'(ack),      32'(exp_ack));
            check("nack",     32'(nack),     32'(exp_nack));
            check("unlock",   32'(unlock),   32'(exp_unlock));
            check("d",        32'(d),        32'(exp_d));
            check("lockout",  32'(lockout),  32'(m_lock));
            check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
        end
    end

    // Driver: raise req[idx], hold until ack/nack, report latency from the
    // first grant (or nack) cycle and the number of unlock cycles seen.
    task automatic do_req(input int idx, input logic [7:0] k, input logic [7:0] dat,
                          output int lat, output int ucnt, output bit got_ack, output bit got_nack);
        bit started;
        @(negedge clk);
        if (idx == 0) begin key0 = k; wdata0 = dat; end
        else          begin key1 = k; wdata1 = dat; end
        req[idx] = 1'b1;
        lat = 0; ucnt = 0; got_ack = 1'b0; got_nack = 1'b0; started = 1'b0;
        for (int c = 0; c < 60 && !(got_ack || got_nack); c++) begin
            @(negedge clk);
            if (unlock) ucnt++;
            if (grant[idx] || nack[idx]) started = 1'b1;
            if (ack[idx])  got_ack  = 1'b1;
            if (nack[idx]) got_nack = 1'b1;
            if (started && !(got_ack || got_nack)) lat++;
        end
        req[idx] = 1'b0;
        check("req_done", 32'(got_ack | got_nack), 32'd1);
    endtask

    logic [1:0] exp_q[$];

    initial begin : stim
        int         lat, uc, cnt;
        bit         ga, gn, found;
        logic [1:0] gseq[$];
        logic [1:0] aseq[$];
        logic [1:0] prev_g;
        logic [7:0] snap;

        // Reset values
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant",    32'(grant),     32'd0);
        check("rst_ack",      32'(ack),       32'd0);
        check("rst_nack",     32'(nack),      32'd0);
        check("rst_unlock",   32'(unlock),    32'd0);
        check("rst_d",        32'(d),         32'd0);
        check("rst_lockout",  32'(lockout),   32'd0);
        check("rst_fail_cnt", 32'(fail_cnt),  32'd0);
        check("rst_state",    32'(state_dbg), 32'd0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // Single good write
        do_req(0, 8'hA5, 8'h3C, lat, uc, ga, gn);
        check("good_ack",     32'(ga),  32'd1);
        check("good_latency", 32'(lat), 32'd6);
        check("good_unlocks", 32'(uc),  32'd4);
        @(negedge clk);
        check("good_prot",    32'(prot_reg), 32'h3C);

        // Bad key then good key from requester 1
        do_req(1, 8'h00, 8'h99, lat, uc, ga, gn);
        check("bad_nack",     32'(gn),       32'd1);
        check("bad_latency",  32'(lat),      32'd2);
        check("bad_unlocks",  32'(uc),       32'd0);
        check("bad_fail_cnt", 32'(fail_cnt), 32'd1);
        do_req(1, 8'hA5, 8'h42, lat, uc, ga, gn);
        check("recover_ack",  32'(ga),       32'd1);
        check("recover_fail", 32'(fail_cnt), 32'd0);

        // Three bad keys latch lockout
        do_req(0, 8'h11, 8'h01, lat, uc, ga, gn);
        do_req(0, 8'h22, 8'h02, lat, uc, ga, gn);
        check("pre_lockout",  32'(lockout),  32'd0);
        do_req(0, 8'h33, 8'h03, lat, uc, ga, gn);
        check("lock_nack",    32'(gn),       32'd1);
        check("lock_set",     32'(lockout),  32'd1);
        check("lock_fail",    32'(fail_cnt), 32'd3);
        do_req(0, 8'hA5, 8'h55, lat, uc, ga, gn);
        check("lock_good_nack",   32'(gn), 32'd1);
        check("lock_good_unlock", 32'(uc), 32'd0);

        // Held request in lockout is refused every other cycle
        @(negedge clk);
        req[1] = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (nack[1]) cnt++;
        end
        req[1] = 1'b0;
        check("lock_nack_pulses", 32'(cnt), 32'd3);

        // Reset clears lockout
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_lockout_clr", 32'(lockout),  32'd0);
        check("rst_fail_clr",    32'(fail_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Contention: both requesters held, grants alternate from requester 0
        @(negedge clk);
        key0 = 8'hA5; key1 = 8'hA5; wdata0 = 8'h11; wdata1 = 8'h22;
        req = 2'b11;
        prev_g = 2'b00;
        for (int c = 0; c < 100 && aseq.size() < 3; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && prev_g == 2'b00) gseq.push_back(grant);
            if (ack != 2'b00) aseq.push_back(ack);
            prev_g = grant;
        end
        req = 2'b00;
        check("cont_grants", 32'(gseq.size()), 32'd3);
        check("cont_acks",   32'(aseq.size()), 32'd3);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 3; i++) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            check("cont_grant_seq", (i < gseq.size()) ? 32'(gseq[i]) : 32'hFFFF, 32'(e));
            check("cont_ack_seq",   (i < aseq.size()) ? 32'(aseq[i]) : 32'hFFFF, 32'(e));
        end
        repeat (2) @(negedge clk);

        // Capture integrity: inputs change and req drops after the grant
        key0 = 8'hA5; wdata0 = 8'h5A; req[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (grant[0]) found = 1'b1;
        end
        check("cap_granted", 32'(found), 32'd1);
        key0 = 8'h00; wdata0 = 8'hFF; req[0] = 1'b0;
        ga = 1'b0; uc = 0;
        for (int c = 0; c < 20 && !ga; c++) begin
            @(negedge clk);
            if (unlock) begin
                uc++;
                check("cap_d", 32'(d), 32'h5A);
            end
            if (ack[0]) ga = 1'b1;
        end
        check("cap_ack",     32'(ga), 32'd1);
        check("cap_unlocks", 32'(uc), 32'd4);
        @(negedge clk);
        check("cap_prot", 32'(prot_reg), 32'h5A);

        // Reset during the second unlock cycle
        @(negedge clk);
        key1 = 8'hA5; wdata1 = 8'h77; req[1] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (unlock) found = 1'b1;
        end
        check("mid_unlock_seen", 32'(found), 32'd1);
        req[1] = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_unlock",  32'(unlock),   32'd0);
        check("mid_grant",   32'(grant),    32'd0);
        check("mid_ack",     32'(ack),      32'd0);
        check("mid_nack",    32'(nack),     32'd0);
        check("mid_d",       32'(d),        32'd0);
        check("mid_lockout", 32'(lockout),  32'd0);
        check("mid_fail",    32'(fail_cnt), 32'd0);
        check("mid_prot",    32'(prot_reg), 32'h77);
        snap = prot_reg;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_prot_kept", 32'(prot_reg), 32'(snap));
        check("mid_idle",      32'(state_dbg), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_window_arbiter.md
# lock_window_arbiter

Sequencing controller for a lock-on-reset protected register. Two requesters share one protected register. Each requester must present a matching key before the block opens a bounded unlock window and drives its write data onto the register's `d` input. The block re-locks automatically when the window closes. Repeated bad keys latch a permanent lockout that only reset clears.

## Interface
- DATA_W, 8: width of protected register data and of each requester's write data
- KEY_W, 8: key width
- KEY, 8'hA5: expected key value (KEY_W bits)
- WINDOW, 4: cycles `unlock` stays high per granted write (≥1)
- MAX_FAIL, 3: consecutive key mismatches that trigger lockout (≥1)

- clk  in  1  clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  2  per-requester request; held high until that requester's ack or nack
- key0, key1  in  KEY_W  key presented by requester 0 / 1
- wdata0, wdata1  in  DATA_W  write data from requester 0 / 1
- grant  out  2  one-hot owner of the current operation, registered
- ack  out  2  one-cycle pulse: write completed
- nack  out  2  one-cycle pulse: key rejected, or request refused because of lockout
- unlock  out  1  to the protected register's unlock input
- d  out  DATA_W  to the protected register's data input
- lockout  out  1  sticky lockout flag
- fail_cnt  out  $clog2(MAX_FAIL+1)  current count of consecutive mismatches

## Operation
- States: IDLE, CHECK, OPEN, RELOCK, LOCKOUT.
- Reset values: state=IDLE, grant=0, ack=0, nack=0, unlock=0, d=0, lockout=0, fail_cnt=0, round-robin pointer favours requester 0.
- IDLE with any `req` bit set:
  - Pick one requester round-robin. The last-granted requester gets lower priority when both request.
  - Capture that requester's key and wdata into internal registers.
  - Set its `grant` bit and go to CHECK.
- Capture rule: captured values are used for the whole operation. Input changes after the grant edge are ignored. So is dropping `req` mid-operation.
- CHECK, one cycle: compare the captured key with KEY.
  - Match: clear fail_cnt and go to OPEN.
  - Mismatch: pulse `nack[owner]`, clear grant, increment fail_cnt.
    - If the new fail_cnt equals MAX_FAIL, set lockout and go to LOCKOUT.
    - Otherwise go to IDLE.
- OPEN: `unlock`=1 and `d`=captured wdata for exactly WINDOW cycles, timed by an internal counter. Then go to RELOCK.
- RELOCK, one cycle: `unlock`=0, pulse `ack[owner]`, clear grant, go to IDLE. `d` holds its last value.
- LOCKOUT, terminal until resetn:
  - `unlock` is forced 0 and `grant` stays 0.
  - Any `req` bit high in a cycle produces a `nack` pulse for that requester on the next cycle. This repeats every other cycle while `req` is held, because nack acts as the completion.
- `unlock` is high only in OPEN. No state path asserts it without a preceding CHECK match.
- fail_cnt saturates at MAX_FAIL and never wraps.

## Timing
- Request sampled in IDLE at edge N:
  - grant visible after edge N.
  - CHECK during cycle N+1.
  - `unlock` high from edge N+2 through edge N+1+WINDOW.
  - RELOCK with `ack` high in cycle N+2+WINDOW.
  - IDLE at N+3+WINDOW.
- Total successful operation: WINDOW+3 cycles from request sample to IDLE.
- Rejected key: `nack` high in the cycle after CHECK, back in IDLE at that same edge. That is 2 cycles from request sample to the nack edge.
- Back-to-back: a requester still holding `req` during its own ack cycle is not regranted if the other requester is waiting.
- Simultaneous requests: the round-robin pointer decides; the loser keeps `req` high and is served next.
- Reset mid-operation (any state, including OPEN): all outputs drop to their reset values asynchronously. `unlock` falls without waiting for a clock edge. LOCKOUT is also cleared.
- `ack` and `nack` are never both high, and at most one bit of each is set.

## Test plan
- Single good write: reset, req0=1, key0=A5, wdata0=3C → grant=01 next cycle; unlock=1 and d=3C for exactly 4 cycles; ack=01 one cycle later; protected register reads 3C after re-lock.
- Bad key: req1, key1=00 → nack=10 two cycles after the request, unlock never rises, fail_cnt=1; a following good-key write from req1 clears fail_cnt to 0.
- Lockout: three consecutive bad keys → lockout=1 after the third nack; then a good key A5 → nack, unlock stays 0; assert resetn=0 → lockout=0, fail_cnt=0.
- Contention: req=11 held with valid keys → grants alternate 01, 10, 01; each ack goes to the granted requester; the unlock windows never overlap and `d` matches the owner's data.
- Capture integrity: after grant, change wdata0 and key0 and drop req0 → the write still completes with the originally captured data and ack is issued.
- Reset mid-window: drive resetn low during the second OPEN cycle → unlock=0 immediately, before the next edge; all outputs at reset values; the protected register value is unchanged afterwards.
